// File: rtl/cpu_pkg.sv
// Shared CPU definitions: MIPS opcode constants and the instruction loader's state encoding.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FLUSH,
    DONE
  } loader_state_e;

endpackage

// File: rtl/ir_pack.sv
// Combinational encoder: packs decoded instruction fields into a 32-bit MIPS word,
// placing the destination register where the decode side expects to find it.
module ir_pack
  import cpu_pkg::*;
(
  input  logic [5:0]  op_i,
  input  logic [4:0]  ar_i,
  input  logic [4:0]  br_i,
  input  logic [4:0]  rdr_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] ind_i,
  output logic [31:0] word_o
);

  always_comb begin
    word_o = {op_i, ar_i, br_i, imm_i};
    case (op_i)
      OP_J, OP_JAL:   word_o = {op_i, ind_i};
      // lw and addi write rt, so the destination lands in the rt slot
      OP_LW, OP_ADDI: word_o = {op_i, ar_i, rdr_i, imm_i};
      OP_SW:          word_o = {op_i, ar_i, br_i, imm_i};
      OP_RTYPE:       word_o = {op_i, ar_i, br_i, rdr_i, imm_i[10:0]};
      default:        word_o = {op_i, ar_i, br_i, imm_i};
    endcase
  end

endmodule

// File: rtl/ir_assembler_loader.sv
// Streams field tuples into instruction memory: packs each accepted tuple and writes it
// one cycle later at consecutive word addresses, ending on last or on address wrap.
module ir_assembler_loader
  import cpu_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [5:0]    op,
  input  logic [4:0]    ar,
  input  logic [4:0]    br,
  input  logic [4:0]    rdr,
  input  logic [15:0]   imm,
  input  logic [25:0]   ind,
  input  logic          last,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          done,
  output logic          ovf,
  output logic [AW:0]   count
);

  localparam logic [AW-1:0] ADDR_MAX  = '1;
  localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   COUNT_MAX = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   COUNT_ONE = {{AW{1'b0}}, 1'b1};

  loader_state_e state_q, state_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   packed_word;
  logic          accept;

  ir_pack u_pack (
    .op_i   (op),
    .ar_i   (ar),
    .br_i   (br),
    .rdr_i  (rdr),
    .imm_i  (imm),
    .ind_i  (ind),
    .word_o (packed_word)
  );

  // in_ready comes straight from the state register, never from in_valid
  assign in_ready = (state_q == LOAD);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    ovf_d     = ovf_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    count_d   = count_q;
    if (we_q && (count_q != COUNT_MAX)) begin
      count_d = count_q + COUNT_ONE;
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = LOAD;
          wr_addr_d = base_addr;
          count_d   = '0;
          ovf_d     = 1'b0;
        end
      end
      LOAD: begin
        if (accept) begin
          we_d      = 1'b1;
          addr_d    = wr_addr_q;
          wdata_d   = packed_word;
          wr_addr_d = wr_addr_q + ADDR_ONE;
          if (last) begin
            state_d = FLUSH;
          end else if (wr_addr_q == ADDR_MAX) begin
            // the next address would wrap onto the start of memory, so the session stops here
            state_d = FLUSH;
            ovf_d   = 1'b1;
          end
        end
      end
      FLUSH: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_addr_q <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign done      = (state_q == DONE);
  assign ovf       = ovf_q;
  assign count     = count_q;

endmodule

// File: tb/tb_ir_assembler_loader.sv
// Directed bench for ir_assembler_loader: table-driven packing bursts plus hand-written
// sequences for address wrap, restart from DONE, random in_valid and mid-session reset.
module tb_ir_assembler_loader;

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  ar;
    logic [4:0]  br;
    logic [4:0]  rdr;
    logic [15:0] imm;
    logic [25:0] ind;
    logic        last;
    logic [31:0] expWord;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  base_addr;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  op;
  logic [4:0]  ar;
  logic [4:0]  br;
  logic [4:0]  rdr;
  logic [15:0] imm;
  logic [25:0] ind;
  logic        last;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        done;
  logic        ovf;
  logic [8:0]  count;

  int   vectorsApplied = 0;
  int   miscompares    = 0;
  vec_t vecs[9];

  ir_assembler_loader #(.AW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .ar        (ar),
    .br        (br),
    .rdr       (rdr),
    .imm       (imm),
    .ind       (ind),
    .last      (last),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .done      (done),
    .ovf       (ovf),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectorsApplied++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    in_valid = 1'b1;
    op       = v.op;
    ar       = v.ar;
    br       = v.br;
    rdr      = v.rdr;
    imm      = v.imm;
    ind      = v.ind;
    last     = v.last;
  endtask

  task automatic pulseStart(input logic [7:0] base);
    start     = 1'b1;
    base_addr = base;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Session of n back-to-back tuples taken from the table, last flag taken from the table
  task automatic runBurst(input int first, input int n, input logic [7:0] base);
    logic [7:0] a;
    pulseStart(base);
    for (int i = 0; i < n; i++) begin
      applyStimulus(vecs[first + i]);
      @(negedge clk);
      checkOutput("burst_in_ready", in_ready, 1'b1);
      if (i == 0) begin
        checkOutput("start_clears_done", done, 1'b0);
        checkOutput("start_clears_ovf", ovf, 1'b0);
        checkOutput("start_clears_count", count, 9'd0);
        checkOutput("first_no_we", mem_we, 1'b0);
      end else begin
        a = base + 8'(i - 1);
        checkOutput("burst_we", mem_we, 1'b1);
        checkOutput("burst_addr", mem_addr, a);
        checkOutput("burst_data", mem_wdata, vecs[first + i - 1].expWord);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    a = base + 8'(n - 1);
    checkOutput("flush_we", mem_we, 1'b1);
    checkOutput("flush_addr", mem_addr, a);
    checkOutput("flush_data", mem_wdata, vecs[first + n - 1].expWord);
    checkOutput("flush_in_ready", in_ready, 1'b0);
    checkOutput("flush_not_done", done, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("done_we", mem_we, 1'b0);
    checkOutput("done_flag", done, 1'b1);
    checkOutput("done_count", count, 9'(n));
    checkOutput("done_ovf", ovf, 1'b0);
  endtask

  initial begin
    vec_t v;
    logic expWe;
    logic [7:0] expAddr;
    logic [31:0] expWord;
    logic drvValid;
    int sent;
    int cyc;

    vecs[0] = '{6'h23, 5'd1,  5'd0,  5'd2,  16'h0004, 26'h0,       1'b1, 32'h8C220004};
    vecs[1] = '{6'h2B, 5'd1,  5'd3,  5'd0,  16'h0008, 26'h0,       1'b0, 32'hAC230008};
    vecs[2] = '{6'h08, 5'd0,  5'd0,  5'd5,  16'hFFFF, 26'h0,       1'b0, 32'h2005FFFF};
    vecs[3] = '{6'h00, 5'd1,  5'd2,  5'd3,  16'h0020, 26'h0,       1'b0, 32'h00221820};
    vecs[4] = '{6'h02, 5'd0,  5'd0,  5'd0,  16'h0000, 26'h10,      1'b1, 32'h08000010};
    vecs[5] = '{6'h03, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FFFFFF, 1'b0, 32'h0FFFFFFF};
    vecs[6] = '{6'h04, 5'd2,  5'd3,  5'd7,  16'h1234, 26'h0,       1'b0, 32'h10431234};
    vecs[7] = '{6'h00, 5'd0,  5'd4,  5'd9,  16'hF8C0, 26'h0,       1'b0, 32'h000448C0};
    vecs[8] = '{6'h23, 5'd31, 5'd7,  5'd8,  16'h8000, 26'h0,       1'b1, 32'h8FE88000};

    rst = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0;
    op = '0; ar = '0; br = '0; rdr = '0; imm = '0; ind = '0; last = 1'b0;
    @(negedge clk);
    checkOutput("rst_in_ready", in_ready, 1'b0);
    checkOutput("rst_we", mem_we, 1'b0);
    checkOutput("rst_addr", mem_addr, 8'h00);
    checkOutput("rst_data", mem_wdata, 32'h0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_ovf", ovf, 1'b0);
    checkOutput("rst_count", count, 9'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;

    runBurst(0, 1, 8'h10);
    runBurst(1, 4, 8'h00);
    runBurst(5, 4, 8'hA0);

    // Address wrap: three tuples from 0xFE, only two are taken
    pulseStart(8'hFE);
    v = vecs[1]; v.last = 1'b0;
    applyStimulus(v);
    @(posedge clk);
    #1;
    v = vecs[2]; v.last = 1'b0;
    applyStimulus(v);
    @(negedge clk);
    checkOutput("wrap_we0", mem_we, 1'b1);
    checkOutput("wrap_addr0", mem_addr, 8'hFE);
    checkOutput("wrap_data0", mem_wdata, vecs[1].expWord);
    @(posedge clk);
    #1;
    v = vecs[3]; v.last = 1'b1;
    applyStimulus(v);
    @(negedge clk);
    checkOutput("wrap_in_ready", in_ready, 1'b0);
    checkOutput("wrap_we1", mem_we, 1'b1);
    checkOutput("wrap_addr1", mem_addr, 8'hFF);
    checkOutput("wrap_data1", mem_wdata, vecs[2].expWord);
    checkOutput("wrap_ovf_set", ovf, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("wrap_third_dropped", mem_we, 1'b0);
    checkOutput("wrap_done", done, 1'b1);
    checkOutput("wrap_ovf", ovf, 1'b1);
    checkOutput("wrap_count", count, 9'd2);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("wrap_no_late_we", mem_we, 1'b0);
    @(posedge clk);
    #1;

    // Restart from DONE clears done/ovf/count and writes at the new base
    runBurst(0, 1, 8'h40);

    // Random in_valid with stray start pulses during LOAD
    pulseStart(8'h20);
    expWe = 1'b0; expAddr = '0; expWord = '0; sent = 0; cyc = 0;
    while (sent < 6 && cyc < 200) begin
      drvValid  = 1'($urandom_range(0, 1));
      start     = ($urandom_range(0, 3) == 0);
      base_addr = 8'h80;
      if (drvValid) begin
        v = vecs[2];
        v.imm = 16'(sent);
        v.last = (sent == 5);
        applyStimulus(v);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      checkOutput("rand_we", mem_we, expWe);
      if (expWe) begin
        checkOutput("rand_addr", mem_addr, expAddr);
        checkOutput("rand_data", mem_wdata, expWord);
      end
      @(posedge clk);
      if (drvValid) begin
        expWe   = 1'b1;
        expAddr = 8'h20 + 8'(sent);
        expWord = 32'h20050000 + 32'(sent);
        sent++;
      end else begin
        expWe = 1'b0;
      end
      #1;
      cyc++;
    end
    start = 1'b0;
    in_valid = 1'b0;
    checkOutput("rand_all_sent", sent, 6);
    @(negedge clk);
    checkOutput("rand_flush_we", mem_we, 1'b1);
    checkOutput("rand_flush_addr", mem_addr, 8'h25);
    checkOutput("rand_flush_data", mem_wdata, 32'h20050005);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("rand_done", done, 1'b1);
    checkOutput("rand_count", count, 9'd6);
    @(posedge clk);
    #1;

    // Reset the cycle after an accept discards the pending write
    pulseStart(8'h30);
    v = vecs[1]; v.last = 1'b0;
    applyStimulus(v);
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("midrst_we", mem_we, 1'b0);
    checkOutput("midrst_addr", mem_addr, 8'h00);
    checkOutput("midrst_data", mem_wdata, 32'h0);
    checkOutput("midrst_in_ready", in_ready, 1'b0);
    checkOutput("midrst_done", done, 1'b0);
    checkOutput("midrst_count", count, 9'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("postrst_we", mem_we, 1'b0);
    @(posedge clk);
    #1;
    runBurst(0, 1, 8'h50);

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
